miriscv_irq_ctrl: RTL

MIRISCV_IRQ_CTRL -- requirements
Module: miriscv_irq_ctrl

---
 rtl/miriscv_irq_pkg.sv | 21 ++
 rtl/miriscv_irq_detect.sv | 32 +++
 rtl/miriscv_irq_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/miriscv_irq_pkg.sv
// Shared constants, FSM state type and helpers for the miriscv interrupt controller.
package miriscv_irq_pkg;

   localparam int          N_IRQ           = 16;
   localparam int          IRQ_IDX_W       = $clog2(N_IRQ);
   localparam logic [31:0] MCAUSE_IRQ_BASE = 32'h8000_0010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      ISSUE = 2'd2
   } irq_state_e;

   function automatic logic [N_IRQ-1:0] irq_onehot(input logic [IRQ_IDX_W-1:0] idx);
      logic [N_IRQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/miriscv_irq_detect.sv
// Request detection: level mode by default, rising-edge mode when IRQ_EDGE_DETECT_EN is defined.
module miriscv_irq_detect
   import miriscv_irq_pkg::*;
(
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic [N_IRQ-1:0] irq,
   output logic [N_IRQ-1:0] req_set
);

`ifdef IRQ_EDGE_DETECT_EN
   logic [N_IRQ-1:0] hist_reg;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) hist_reg <= '0;
      else          hist_reg <= irq;
   end

   // A line held high sets pending only once, on its first high cycle.
   for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_edge
      assign req_set[gi] = irq[gi] & ~hist_reg[gi];
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk_i ^ arstn_i;

   for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_level
      assign req_set[gi] = irq[gi];
   end
`endif

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Round-robin interrupt controller for miriscv: pending latch, scan FSM, mcause/ack generation.
// Build option: define IRQ_EDGE_DETECT_EN for rising-edge request detection (level mode otherwise).
module miriscv_irq_ctrl
   import miriscv_irq_pkg::*;
(
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic [N_IRQ-1:0] irq_i,
   input  logic [31:0]      mie_i,
   input  logic             int_rst_i,
   output logic             int_o,
   output logic [31:0]      mcause_o,
   output logic [N_IRQ-1:0] irq_ack_o
);

   irq_state_e           state_reg, state_next;
   logic [N_IRQ-1:0]     pending_reg, pending_next;
   logic [N_IRQ-1:0]     req_set, req_clr, enabled;
   logic [IRQ_IDX_W-1:0] ptr_reg, ptr_next;
   logic [IRQ_IDX_W-1:0] id_reg, id_next;
   logic                 int_reg, int_next;
   logic [31:0]          mcause_reg, mcause_next;
   logic [N_IRQ-1:0]     ack_reg, ack_next;
   logic [15:0]          unused_mie_hi;

   assign unused_mie_hi = mie_i[31:16];

   miriscv_irq_detect u_detect (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .irq     (irq_i),
      .req_set (req_set)
   );

   assign enabled = pending_reg & mie_i[N_IRQ-1:0];

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      id_next     = id_reg;
      int_next    = int_reg;
      mcause_next = mcause_reg;
      ack_next    = '0;
      req_clr     = '0;
      case (state_reg)
         IDLE: begin
            if (|enabled) state_next = SCAN;
         end
         SCAN: begin
            if (enabled[ptr_reg]) begin
               id_next     = ptr_reg;
               int_next    = 1'b1;
               mcause_next = MCAUSE_IRQ_BASE + {{(32-IRQ_IDX_W){1'b0}}, ptr_reg};
               state_next  = ISSUE;
            end else if (!(|enabled)) begin
               state_next = IDLE;
            end else begin
               ptr_next = ptr_reg + 1'b1;
            end
         end
         ISSUE: begin
            // Served source moves the pointer just past it so every source gets a turn.
            if (int_rst_i) begin
               req_clr    = irq_onehot(id_reg);
               ack_next   = req_clr;
               ptr_next   = id_reg + 1'b1;
               int_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // A new request on the line being cleared wins over the clear.
      pending_next = (pending_reg & ~req_clr) | req_set;
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_reg   <= IDLE;
         pending_reg <= '0;
         ptr_reg     <= '0;
         id_reg      <= '0;
         int_reg     <= 1'b0;
         mcause_reg  <= '0;
         ack_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         ptr_reg     <= ptr_next;
         id_reg      <= id_next;
         int_reg     <= int_next;
         mcause_reg  <= mcause_next;
         ack_reg     <= ack_next;
      end
   end

   assign int_o     = int_reg;
   assign mcause_o  = mcause_reg;
   assign irq_ack_o = ack_reg;

endmodule
